freq_m_ctrl: RTL
================

# freq_m_ctrl

Measurement controller for the frequency-meter core. It drives the meter's gate divider (`time_del`), captures each finished measurement, and auto-ranges the gate time from the raw count and the overflow flag. It discards the first result after any range change and offers results to the Nios-side reader through a one-entry valid/ready buffer. It runs in the `clk_base` domain, between the meter core and the Avalon register slave.

## Interface
Parameters:
- `DEL_MAX`, 8: largest allowed `time_del`. Integrator guarantees `freq_base >> DEL_MAX >= 4`.
- `LOW_TH`, 32'd1000: raw count below this requests a longer gate (decrement `time_del`).
- `HIGH_TH`, 32'd100_000_000: raw count above this requests a shorter gate (increment `time_del`).

Ports:
- `clk_base`  in  1  system/reference clock; also clocks the meter's reference counter.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; 0 holds the FSM in IDLE.
- `auto_en`  in  1  1 = auto-range; 0 = use `manual_del`.
- `manual_del`  in  5  gate divider used when `auto_en=0`, saturated to `DEL_MAX`.
- `cout_b`  in  1  meter end-of-gate pulse, one `clk_base` cycle wide.
- `freq_mem`  in  32  meter result, already shifted left by `time_del`.
- `cout_i`  in  1  meter count-overflow flag, asynchronous; integrator stretches it to at least 2 `clk_base` cycles.
- `time_del`  out  32  gate divider to the meter; bits [31:5] are always 0.
- `res_data`  out  32  captured frequency in Hz.
- `res_del`  out  5  `time_del` in force for `res_data`.
- `res_ovf`  out  1  overflow occurred during that gate.
- `res_lost`  out  1  one or more earlier results were overwritten unread.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  reader accepts.

## Operation
- Synchronize `cout_i` with 2 flip-flops. A rising edge sets the sticky `ovf_seen` flag.
- Register `cout_b` into `cout_b_d`. `fall = cout_b_d & ~cout_b`.
- FSM states are IDLE, SKIP, MEASURE and CAPTURE.
- IDLE
  - If `enable=1`: load the target divider, then go to SKIP.
  - Target divider: `auto_en=1` uses `DEL_MAX`; `auto_en=0` uses `min(manual_del, DEL_MAX)`.
- SKIP: on `fall`, clear `ovf_seen`, write no result, go to MEASURE. This discards the gate whose divider changed partway through.
- MEASURE: on `fall`, go to CAPTURE.
- CAPTURE (one cycle)
  - Compute `raw = freq_mem >> time_del`.
  - Load `res_data = freq_mem`, `res_del = time_del`, `res_ovf = ovf_seen`. Clear `ovf_seen`.
  - If `res_valid` was already 1 and not handshaken this cycle, set `res_lost=1`.
  - Set `res_valid=1`.
  - Next divider, auto mode:
    - `ovf_seen` or `raw > HIGH_TH`, and `time_del < DEL_MAX`: `time_del + 1`.
    - Otherwise, `raw < LOW_TH` and `time_del > 0`: `time_del - 1`.
    - Otherwise: unchanged.
  - Next divider, manual mode: the saturated `manual_del`.
  - If the divider changes, write `time_del` this cycle and go to SKIP; otherwise go to MEASURE.
- `time_del` is written only in IDLE exit or CAPTURE. The meter's reference counter is then at most 2, which is below `freq_base >> time_del`, so it can never miss its terminal count.
- `enable` falling takes effect in any state: go to IDLE next cycle. `res_*` are kept and `time_del` holds its value.
- Handshake
  - A transfer occurs when `res_valid & res_ready` is high on a rising edge.
  - On a transfer, `res_valid` clears and `res_lost` clears, unless CAPTURE loads in the same cycle. In that case the new result wins: `res_valid` stays 1 and `res_lost` becomes 0.
  - `res_*` are stable while `res_valid=1` and no CAPTURE occurs.

## Timing
- Reset values: `time_del=0`, `res_data=0`, `res_del=0`, `res_ovf=0`, `res_lost=0`, `res_valid=0`, FSM in IDLE, `ovf_seen=0`.
- `cout_b` high at cycle N gives `fall` at N+1 and CAPTURE at N+2. `res_valid` rises at N+3.
- `freq_mem` is sampled in CAPTURE, at least one cycle after the meter updates it on the falling edge of `cout_b`.
- An overflow edge seen in the same cycle as the CAPTURE clear is kept, and counted for the next gate.
- After a range change, the first valid result appears after two gate periods.
- Reset asserted mid-gate: all outputs return to reset values immediately. The meter completes its gate unaffected.

## Test plan
- Manual mode: `auto_en=0`, `manual_del=2`, `freq_base=1000`, 10 kHz input → `time_del=2`, first `fall` discarded, then `res_data=10000`, `res_del=2`, `res_valid=1`.
- Auto down-range: start at `DEL_MAX=8`, raw count 100 < `LOW_TH` → `time_del` steps 8,7,… to 0, one discarded gate per step, a result after every kept gate.
- Overflow: `cout_i` pulsed for 3 cycles during a gate at `time_del=3` → that result has `res_ovf=1`, `time_del` becomes 4, and the next gate is discarded.
- Backpressure: `res_ready=0` across two captures → second result replaces the first with `res_lost=1`. Raise `res_ready` → `res_valid=0` next cycle.
- Simultaneous transfer and capture: `res_ready=1` in the CAPTURE cycle → `res_valid` stays 1, the new data is shown, `res_lost=0`.
- Reset/enable: assert `rst_n=0` in MEASURE → all outputs 0. Drop `enable` mid-SKIP → IDLE, with no result produced.

Source files
------------

// File: rtl/freq_m_ctrl.sv
// Frequency-meter measurement controller: gate divider auto-ranging,
// result capture and a one-entry valid/ready result buffer.
module freq_m_ctrl #(
  parameter int unsigned DEL_MAX = 8,
  parameter logic [31:0] LOW_TH  = 32'd1000,
  parameter logic [31:0] HIGH_TH = 32'd100_000_000
) (
  input  logic        clk_base,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        auto_en,
  input  logic [4:0]  manual_del,
  input  logic        cout_b,
  input  logic [31:0] freq_mem,
  input  logic        cout_i,
  output logic [31:0] time_del,
  output logic [31:0] res_data,
  output logic [4:0]  res_del,
  output logic        res_ovf,
  output logic        res_lost,
  output logic        res_valid,
  input  logic        res_ready
);

  localparam logic [4:0] DMAX = 5'(DEL_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_MEAS,
    S_CAP
  } state_e;

  state_e      state_q;
  logic [4:0]  del_q;
  logic        cout_b_d_q;
  logic [2:0]  ovf_sync_q;
  logic        ovf_seen_q;
  logic [31:0] res_data_q;
  logic [4:0]  res_del_q;
  logic        res_ovf_q;
  logic        res_lost_q;
  logic        res_valid_q;

  logic        fall;
  logic        ovf_rise;
  logic        xfer;
  logic [31:0] raw;
  logic [4:0]  man_sat;
  logic [4:0]  tgt_del;
  logic [4:0]  auto_del;
  logic [4:0]  nxt_del;

  assign fall     = cout_b_d_q & ~cout_b;
  assign ovf_rise = ovf_sync_q[1] & ~ovf_sync_q[2];
  assign xfer     = res_valid_q & res_ready;
  assign raw      = freq_mem >> del_q;
  assign man_sat  = (manual_del > DMAX) ? DMAX : manual_del;
  assign tgt_del  = auto_en ? DMAX : man_sat;
  assign nxt_del  = auto_en ? auto_del : man_sat;

  always_comb begin
    auto_del = del_q;
    if ((ovf_seen_q || raw > HIGH_TH) && del_q < DMAX)
      auto_del = del_q + 5'd1;
    else if (raw < LOW_TH && del_q != 5'd0)
      auto_del = del_q - 5'd1;
  end

  always_ff @(posedge clk_base or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      del_q       <= 5'd0;
      cout_b_d_q  <= 1'b0;
      ovf_sync_q  <= 3'b000;
      ovf_seen_q  <= 1'b0;
      res_data_q  <= 32'd0;
      res_del_q   <= 5'd0;
      res_ovf_q   <= 1'b0;
      res_lost_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      cout_b_d_q <= cout_b;
      ovf_sync_q <= {ovf_sync_q[1:0], cout_i};
      if (xfer) begin
        res_valid_q <= 1'b0;
        res_lost_q  <= 1'b0;
      end
      if (!enable) begin
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            del_q   <= tgt_del;
            state_q <= S_SKIP;
          end
          S_SKIP: begin
            if (fall) begin
              ovf_seen_q <= 1'b0;
              state_q    <= S_MEAS;
            end
          end
          S_MEAS: begin
            if (fall) state_q <= S_CAP;
          end
          S_CAP: begin
            res_data_q  <= freq_mem;
            res_del_q   <= del_q;
            res_ovf_q   <= ovf_seen_q;
            res_lost_q  <= res_valid_q & ~res_ready;
            res_valid_q <= 1'b1;
            ovf_seen_q  <= 1'b0;
            if (nxt_del != del_q) begin
              del_q   <= nxt_del;
              state_q <= S_SKIP;
            end else begin
              state_q <= S_MEAS;
            end
          end
        endcase
      end
      // a new overflow edge outranks any clear in the same cycle
      if (ovf_rise) ovf_seen_q <= 1'b1;
    end
  end

  assign time_del  = {27'd0, del_q};
  assign res_data  = res_data_q;
  assign res_del   = res_del_q;
  assign res_ovf   = res_ovf_q;
  assign res_lost  = res_lost_q;
  assign res_valid = res_valid_q;

endmodule
